// File: rtl/uart_frame_assembler.sv
// Packs UART RX bytes into {mode, data, addr} command frames for the cmd FIFO.
// Optional inter-byte timeout: define UART_FRAME_TIMEOUT_EN.
module uart_frame_assembler #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_BYTES  = (ADDR_WIDTH + DATA_WIDTH) / 8 + 1,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           rx_ready,
  input  logic [7:0]                     rx_data,
  input  logic                           frame_ready,
  input  logic                           err_clr,
  output logic                           frame_valid,
  output logic [FRAME_BYTES*8-1:0]       frame_data,
  output logic [ADDR_WIDTH-1:0]          f_addr,
  output logic [DATA_WIDTH-1:0]          f_wdata,
  output logic                           f_mode,
  output logic [$clog2(FRAME_BYTES)-1:0] byte_cnt,
  output logic                           busy,
  output logic                           fmt_err,
  output logic                           drop_err,
  output logic                           timeout_err
);

  localparam int CW = $clog2(FRAME_BYTES);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BYTES - 1);

  if ((ADDR_WIDTH % 8) != 0 || (DATA_WIDTH % 8) != 0
      || TIMEOUT_CLKS < 2) begin : g_bad_cfg
    $error("uart_frame_assembler: illegal parameter set");
  end

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  state_t          state, state_d;
  logic            prev_rdy;
  logic            byte_evt;
  logic            xfer;
  logic            take;
  logic            tmo_hit;
  logic [CW-1:0]   cnt_d;
  logic            fmt_d;
  logic            drop_d;

  assign byte_evt = rx_ready & ~prev_rdy;
  assign xfer     = (state == HOLD) & frame_ready;
  // a byte landing on the transfer edge starts the next frame
  assign take     = byte_evt & ((state == COLLECT) | xfer);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  logic [TW-1:0] idle_cnt;

  assign tmo_hit = (state == COLLECT) && (byte_cnt != '0)
                   && !byte_evt
                   && (idle_cnt == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
    end else if (take || tmo_hit || state != COLLECT
                 || byte_cnt == '0) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = byte_cnt;
    fmt_d   = 1'b0;
    drop_d  = drop_err & ~err_clr;
    if (xfer) state_d = COLLECT;
    if (byte_evt && state == HOLD && !frame_ready) drop_d = 1'b1;
    if (take) begin
      cnt_d = byte_cnt + CW'(1);
      if (byte_cnt == LAST) begin
        cnt_d = '0;
        unique case (1'b1)
          rx_data[7:1] == 7'd0: state_d = HOLD;
          default:              fmt_d   = 1'b1;
        endcase
      end
    end else if (tmo_hit) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= COLLECT;
      byte_cnt    <= '0;
      prev_rdy    <= 1'b1;
      fmt_err     <= 1'b0;
      drop_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      byte_cnt    <= cnt_d;
      prev_rdy    <= rx_ready;
      fmt_err     <= fmt_d;
      drop_err    <= drop_d;
      timeout_err <= tmo_hit;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_data <= '0;
    end else begin
      for (int i = 0; i < FRAME_BYTES; i++) begin
        if (take && byte_cnt == CW'(i)) begin
          frame_data[i*8 +: 8] <= rx_data;
        end
      end
    end
  end

  assign frame_valid = (state == HOLD);
  assign f_addr      = frame_data[ADDR_WIDTH-1:0];
  assign f_wdata     = frame_data[ADDR_WIDTH +: DATA_WIDTH];
  assign f_mode      = frame_data[(FRAME_BYTES-1)*8];
  assign busy        = (byte_cnt != '0) || frame_valid;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler (default widths, TIMEOUT_CLKS=50).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_frame_assembler;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        frame_ready;
  logic        err_clr;
  logic        frame_valid;
  logic [31:0] frame_data;
  logic [15:0] f_addr;
  logic [7:0]  f_wdata;
  logic        f_mode;
  logic [1:0]  byte_cnt;
  logic        busy;
  logic        fmt_err;
  logic        drop_err;
  logic        timeout_err;

  int n_assert = 0;
  int n_fail   = 0;
  logic tmo_seen;

  always #5 clk = ~clk;

  uart_frame_assembler #(
    .TIMEOUT_CLKS(50)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .frame_ready (frame_ready),
    .err_clr     (err_clr),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .f_addr      (f_addr),
    .f_wdata     (f_wdata),
    .f_mode      (f_mode),
    .byte_cnt    (byte_cnt),
    .busy        (busy),
    .fmt_err     (fmt_err),
    .drop_err    (drop_err),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rise(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic fall();
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rise(b);
    fall();
  endtask

  initial begin
    rstn        = 1'b0;
    rx_ready    = 1'b0;
    rx_data     = 8'h00;
    frame_ready = 1'b0;
    err_clr     = 1'b0;
    tmo_seen    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", frame_valid, 0);
    chk("rst_data", frame_data, 0);
    chk("rst_cnt", byte_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fmt", fmt_err, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_tmo", timeout_err, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // normal write frame
    frame_ready = 1'b1;
    send(8'h34);
    chk("wr_cnt1", byte_cnt, 1);
    chk("wr_busy", busy, 1);
    send(8'h12);
    send(8'hAB);
    chk("wr_cnt3", byte_cnt, 3);
    rise(8'h01);
    chk("wr_valid", frame_valid, 1);
    chk("wr_data", frame_data, 32'h01AB1234);
    chk("wr_addr", f_addr, 16'h1234);
    chk("wr_wdata", f_wdata, 8'hAB);
    chk("wr_mode", f_mode, 1);
    chk("wr_cnt0", byte_cnt, 0);
    fall();
    chk("wr_valid_1cyc", frame_valid, 0);
    chk("wr_idle_busy", busy, 0);

    // backpressure with a dropped byte
    frame_ready = 1'b0;
    send(8'h00);
    send(8'h10);
    send(8'h00);
    rise(8'h00);
    chk("bp_valid", frame_valid, 1);
    chk("bp_mode", f_mode, 0);
    chk("bp_addr", f_addr, 16'h1000);
    fall();
    send(8'h55);
    chk("bp_drop", drop_err, 1);
    chk("bp_data_kept", frame_data, 32'h00001000);
    chk("bp_cnt", byte_cnt, 0);
    repeat (20) @(negedge clk);
    chk("bp_still_valid", frame_valid, 1);
    chk("bp_still_data", frame_data, 32'h00001000);
    frame_ready = 1'b1;
    @(negedge clk);
    chk("bp_xfer", frame_valid, 0);
    chk("bp_drop_sticky", drop_err, 1);
    frame_ready = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("bp_clr", drop_err, 0);

    // byte arriving on the transfer edge
    send(8'h02);
    send(8'h00);
    send(8'h00);
    rise(8'h01);
    fall();
    chk("sim_hold", frame_valid, 1);
    rx_data     = 8'h77;
    rx_ready    = 1'b1;
    frame_ready = 1'b1;
    @(negedge clk);
    chk("sim_xfer", frame_valid, 0);
    chk("sim_cnt", byte_cnt, 1);
    chk("sim_b0", frame_data[7:0], 8'h77);
    chk("sim_nodrop", drop_err, 0);
    fall();
    send(8'h66);
    send(8'hCC);
    rise(8'h00);
    chk("sim_valid", frame_valid, 1);
    chk("sim_data", frame_data, 32'h00CC6677);
    fall();
    chk("sim_done", frame_valid, 0);

    // malformed mode byte
    send(8'h01);
    send(8'h02);
    send(8'h03);
    rise(8'h82);
    chk("fmt_pulse", fmt_err, 1);
    chk("fmt_novalid", frame_valid, 0);
    chk("fmt_cnt", byte_cnt, 0);
    fall();
    chk("fmt_one_cyc", fmt_err, 0);
    chk("fmt_novalid2", frame_valid, 0);
    send(8'h78);
    send(8'h56);
    send(8'h9A);
    rise(8'h01);
    chk("fmt_next_valid", frame_valid, 1);
    chk("fmt_next_data", frame_data, 32'h019A5678);
    fall();

    // inter-byte timeout
    send(8'hAA);
    send(8'hBB);
`ifdef UART_FRAME_TIMEOUT_EN
    repeat (48) @(negedge clk);
    chk("tmo_early", timeout_err, 0);
    chk("tmo_cnt_kept", byte_cnt, 2);
    @(negedge clk);
    chk("tmo_pulse", timeout_err, 1);
    chk("tmo_cnt0", byte_cnt, 0);
    @(negedge clk);
    chk("tmo_one_cyc", timeout_err, 0);
    repeat (9) @(negedge clk);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    rise(8'h00);
    chk("tmo_valid", frame_valid, 1);
    chk("tmo_data", frame_data, 32'h00332211);
    fall();
`else
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (timeout_err) tmo_seen = 1'b1;
    end
    chk("notmo_err", tmo_seen, 0);
    chk("notmo_cnt", byte_cnt, 2);
    send(8'h33);
    rise(8'h00);
    chk("notmo_valid", frame_valid, 1);
    chk("notmo_data", frame_data, 32'h0033BBAA);
    fall();
`endif

    // reset mid-frame with rx_ready held high
    send(8'h01);
    send(8'h02);
    send(8'h03);
    chk("mrst_pre_cnt", byte_cnt, 3);
    rx_data  = 8'h44;
    rx_ready = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("mrst_cnt", byte_cnt, 0);
    chk("mrst_valid", frame_valid, 0);
    chk("mrst_data", frame_data, 0);
    chk("mrst_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_nocap_cnt", byte_cnt, 0);
    chk("mrst_nocap_data", frame_data, 0);
    fall();
    rise(8'h44);
    chk("mrst_cap_cnt", byte_cnt, 1);
    chk("mrst_cap_b0", frame_data[7:0], 8'h44);
    fall();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
